// File: rtl/clkgate_ctrl.sv
// clkgate_ctrl: enable controller for an integrated clock-gating cell.
// Keeps the gated clock running while the client requests it, is busy, or
// software forces it on; gates it off after IDLE_CYC consecutive inactive
// cycles and raises ACK WAKE_CYC cycles after the enable rises.
module clkgate_ctrl #(
    parameter int IDLE_CYC = 16,
    parameter int WAKE_CYC = 2,
    parameter int CNT_W    = 5
) (
    input  logic       CK,
    input  logic       RN,
    input  logic       REQ,
    input  logic       BUSY,
    input  logic       FORCE_ON,
    input  logic       TE,
    output logic       E,
    output logic       SE,
    output logic       ACK,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        WAKE  = 2'b01,
        ON    = 2'b10,
        DRAIN = 2'b11
    } state_t;

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Reject parameter sets whose terminal counts do not fit the counters,
    // so the counters can never wrap.
    generate
        if (CNT_W < 1 || CNT_W > 30) begin : g_bad_cnt_w
            $error("clkgate_ctrl: CNT_W must be in 1..30");
        end
        if (IDLE_CYC < 1 || IDLE_CYC > CNT_MAX) begin : g_bad_idle
            $error("clkgate_ctrl: IDLE_CYC out of range 1..2^CNT_W-1");
        end
        if (WAKE_CYC < 1 || WAKE_CYC > CNT_MAX) begin : g_bad_wake
            $error("clkgate_ctrl: WAKE_CYC out of range 1..2^CNT_W-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] wake_cnt_q, wake_cnt_d;
    logic             e_q, e_d;
    logic             ack_q, ack_d;
    logic             act;

    assign act = REQ | BUSY | FORCE_ON;

    // Next-state and counter decisions; E/ACK are decoded from the next state
    // so they leave the flops glitch-free and aligned with STATE.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        unique case (state_q)
            OFF: begin
                if (act) begin
                    state_d    = WAKE;
                    wake_cnt_d = CNT_ZERO;
                end
            end
            WAKE: begin
                // act is deliberately ignored: a started wake always completes.
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d    = ON;
                    idle_cnt_d = CNT_ZERO;
                    wake_cnt_d = CNT_ZERO;
                end else begin
                    wake_cnt_d = wake_cnt_q + CNT_ONE;
                end
            end
            ON: begin
                if (act) begin
                    idle_cnt_d = CNT_ZERO;
                end else if (IDLE_CYC == 1) begin
                    state_d    = OFF;
                    idle_cnt_d = CNT_ZERO;
                end else begin
                    state_d    = DRAIN;
                    idle_cnt_d = CNT_ONE;
                end
            end
            DRAIN: begin
                // Any activity, even on the edge that would gate off, wins.
                if (act) begin
                    state_d    = ON;
                    idle_cnt_d = CNT_ZERO;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d    = OFF;
                    idle_cnt_d = CNT_ZERO;
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d    = OFF;
                idle_cnt_d = CNT_ZERO;
                wake_cnt_d = CNT_ZERO;
            end
        endcase
        e_d   = (state_d != OFF);
        ack_d = (state_d == ON) || (state_d == DRAIN);
    end

    // State, counters and registered outputs; reset abandons any wake/drain.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q    <= OFF;
            idle_cnt_q <= CNT_ZERO;
            wake_cnt_q <= CNT_ZERO;
            e_q        <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            e_q        <= e_d;
            ack_q      <= ack_d;
        end
    end

    assign E     = e_q;
    assign ACK   = ack_q;
    assign SE    = TE;
    assign STATE = state_q;

endmodule

// File: tb/tb_clkgate_ctrl.sv
// Self-checking bench for clkgate_ctrl: default instance plus a
// IDLE_CYC=1/WAKE_CYC=1 corner instance sharing the same stimulus.
module tb_clkgate_ctrl;

    localparam logic [1:0] S_OFF   = 2'b00;
    localparam logic [1:0] S_WAKE  = 2'b01;
    localparam logic [1:0] S_ON    = 2'b10;
    localparam logic [1:0] S_DRAIN = 2'b11;

    logic       ck = 1'b0;
    logic       rn = 1'b0;
    logic       req = 1'b0, busy = 1'b0, force_on = 1'b0, te = 1'b0;
    logic       e, se, ack;
    logic [1:0] state;
    logic       e1, se1, ack1;
    logic [1:0] state1;

    int vectors = 0;
    int miscompares = 0;
    logic [1:0] exp_q[$];

    always #5 ck = ~ck;

    clkgate_ctrl dut (
        .CK(ck), .RN(rn), .REQ(req), .BUSY(busy), .FORCE_ON(force_on), .TE(te),
        .E(e), .SE(se), .ACK(ack), .STATE(state)
    );

    clkgate_ctrl #(.IDLE_CYC(1), .WAKE_CYC(1), .CNT_W(5)) dut1 (
        .CK(ck), .RN(rn), .REQ(req), .BUSY(busy), .FORCE_ON(force_on), .TE(te),
        .E(e1), .SE(se1), .ACK(ack1), .STATE(state1)
    );

    // Expected E/ACK follow from the state table: E on outside OFF, ACK in ON/DRAIN.
    function automatic logic [3:0] expect_vec(logic [1:0] s);
        return {s, (s != S_OFF), (s == S_ON || s == S_DRAIN)};
    endfunction

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic set_act(logic r, logic b, logic f);
        req = r; busy = b; force_on = f;
    endtask

    task automatic do_reset();
        set_act(1'b0, 1'b0, 1'b0);
        rn = 1'b0;
        #2;
        rn = 1'b1;
    endtask

    task automatic test_reset();
        logic [1:0] x;
        rn = 1'b0; te = 1'b1;
        set_act(1'b1, 1'b1, 1'b1);
        exp_q.push_back(S_OFF);
        repeat (2) tick();
        x = exp_q.pop_front();
        vectors++;
        if ({state, e, ack} !== expect_vec(x)) begin
            miscompares++;
            $display("FAIL reset.dut: got {state,e,ack}=%b want %b", {state, e, ack}, expect_vec(x));
        end
        vectors++;
        if ({state1, e1, ack1, se} !== {expect_vec(x), 1'b1}) begin
            miscompares++;
            $display("FAIL reset.dut1_se: got %b want %b", {state1, e1, ack1, se}, {expect_vec(x), 1'b1});
        end
        te = 1'b0;
        set_act(1'b0, 1'b0, 1'b0);
        rn = 1'b1;
        exp_q.push_back(S_OFF);
        tick();
        x = exp_q.pop_front();
        vectors++;
        if ({state, e, ack} !== expect_vec(x)) begin
            miscompares++;
            $display("FAIL reset.release: got %b want %b", {state, e, ack}, expect_vec(x));
        end
    endtask

    // REQ held from edge 0: E after edge 0, ACK after edge 2.
    task automatic test_wake();
        logic [1:0] seq [5] = '{S_WAKE, S_WAKE, S_ON, S_ON, S_ON};
        logic [1:0] x;
        do_reset();
        set_act(1'b1, 1'b0, 1'b0);
        foreach (seq[i]) begin
            exp_q.push_back(seq[i]);
            tick();
            x = exp_q.pop_front();
            vectors++;
            if ({state, e, ack} !== expect_vec(x)) begin
                miscompares++;
                $display("FAIL wake edge %0d: got %b want %b", i, {state, e, ack}, expect_vec(x));
            end
        end
    endtask

    // Continues from ON: 15 DRAIN edges, OFF on the 16th inactive edge.
    task automatic test_idle_off();
        logic [1:0] x;
        set_act(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            exp_q.push_back((i < 15) ? S_DRAIN : S_OFF);
            tick();
            x = exp_q.pop_front();
            vectors++;
            if ({state, e, ack} !== expect_vec(x)) begin
                miscompares++;
                $display("FAIL idle_off edge %0d: got %b want %b", i, {state, e, ack}, expect_vec(x));
            end
        end
    endtask

    // BUSY wakes, 10 idle edges, one BUSY pulse restarts the full idle count.
    task automatic test_drain_abort();
        logic [1:0] x;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            busy = (i < 3) || (i == 13);
            if (i < 2)        exp_q.push_back(S_WAKE);
            else if (i == 2)  exp_q.push_back(S_ON);
            else if (i < 13)  exp_q.push_back(S_DRAIN);
            else if (i == 13) exp_q.push_back(S_ON);
            else if (i < 29)  exp_q.push_back(S_DRAIN);
            else              exp_q.push_back(S_OFF);
            tick();
            x = exp_q.pop_front();
            vectors++;
            if ({state, e, ack} !== expect_vec(x)) begin
                miscompares++;
                $display("FAIL drain_abort edge %0d: got %b want %b", i, {state, e, ack}, expect_vec(x));
            end
            if (i == 12 || i == 13) begin
                vectors++;
                if (dut.idle_cnt_q !== ((i == 12) ? 5'd10 : 5'd0)) begin
                    miscompares++;
                    $display("FAIL drain_abort idle_cnt edge %0d: got %0d want %0d",
                             i, dut.idle_cnt_q, (i == 12) ? 10 : 0);
                end
            end
        end
    endtask

    // One-cycle FORCE_ON: wake completes regardless, then drains to OFF.
    task automatic test_wake_ignores_act();
        logic [1:0] x;
        do_reset();
        for (int i = 0; i < 19; i++) begin
            force_on = (i == 0);
            exp_q.push_back((i < 2) ? S_WAKE : (i == 2) ? S_ON : (i < 18) ? S_DRAIN : S_OFF);
            tick();
            x = exp_q.pop_front();
            vectors++;
            if ({state, e, ack} !== expect_vec(x)) begin
                miscompares++;
                $display("FAIL wake_ignores_act edge %0d: got %b want %b", i, {state, e, ack}, expect_vec(x));
            end
        end
    endtask

    // act on the very edge that would gate off keeps the clock ON.
    task automatic test_priority();
        logic [1:0] x;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            req      = (i < 3);
            force_on = (i == 18);
            if (i < 2)        exp_q.push_back(S_WAKE);
            else if (i == 2)  exp_q.push_back(S_ON);
            else if (i < 18)  exp_q.push_back(S_DRAIN);
            else if (i == 18) exp_q.push_back(S_ON);
            else              exp_q.push_back(S_DRAIN);
            tick();
            x = exp_q.pop_front();
            vectors++;
            if ({state, e, ack} !== expect_vec(x)) begin
                miscompares++;
                $display("FAIL priority edge %0d: got %b want %b", i, {state, e, ack}, expect_vec(x));
            end
        end
    endtask

    // TE toggles in OFF: SE follows it, FSM and outputs untouched.
    task automatic test_test_mode();
        logic [1:0] x;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            te = i[0];
            #1;
            vectors++;
            if (se !== te) begin
                miscompares++;
                $display("FAIL test_mode se step %0d: got %b want %b", i, se, te);
            end
            exp_q.push_back(S_OFF);
            tick();
            x = exp_q.pop_front();
            vectors++;
            if ({state, e, ack} !== expect_vec(x)) begin
                miscompares++;
                $display("FAIL test_mode state step %0d: got %b want %b", i, {state, e, ack}, expect_vec(x));
            end
        end
        te = 1'b0;
    endtask

    // RN pulsed low between edges mid-WAKE clears everything immediately.
    task automatic test_async_reset();
        logic [1:0] x;
        do_reset();
        set_act(1'b1, 1'b0, 1'b0);
        repeat (2) tick();
        #3;
        rn = 1'b0;
        exp_q.push_back(S_OFF);
        #1;
        x = exp_q.pop_front();
        vectors++;
        if ({state, e, ack, dut.wake_cnt_q} !== {expect_vec(x), 5'd0}) begin
            miscompares++;
            $display("FAIL async_reset immediate: got %b want %b",
                     {state, e, ack, dut.wake_cnt_q}, {expect_vec(x), 5'd0});
        end
        #1;
        rn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back((i < 2) ? S_WAKE : S_ON);
            tick();
            x = exp_q.pop_front();
            vectors++;
            if ({state, e, ack} !== expect_vec(x)) begin
                miscompares++;
                $display("FAIL async_reset rewake edge %0d: got %b want %b", i, {state, e, ack}, expect_vec(x));
            end
        end
    endtask

    // IDLE_CYC=1, WAKE_CYC=1 instance: ACK one edge after E, OFF on first idle edge.
    task automatic test_corner();
        logic [1:0] seq [6] = '{S_WAKE, S_ON, S_OFF, S_WAKE, S_ON, S_OFF};
        logic       act_seq [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0] x;
        do_reset();
        foreach (seq[i]) begin
            req = act_seq[i];
            exp_q.push_back(seq[i]);
            tick();
            x = exp_q.pop_front();
            vectors++;
            if ({state1, e1, ack1} !== expect_vec(x)) begin
                miscompares++;
                $display("FAIL corner edge %0d: got %b want %b", i, {state1, e1, ack1}, expect_vec(x));
            end
        end
    endtask

    initial begin
        test_reset();
        test_wake();
        test_idle_off();
        test_drain_abort();
        test_wake_ignores_act();
        test_priority();
        test_test_mode();
        test_async_reset();
        test_corner();
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard: %0d entries left over", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clkgate_ctrl.md
CLKGATE_CTRL -- requirements
Module: clkgate_ctrl

Interface
REQ-001 SHALL have parameter IDLE_CYC, default 16: consecutive inactive cycles before the clock is gated off; legal range 1..2^CNT_W-1.
REQ-002 SHALL have parameter WAKE_CYC, default 2: cycles from E rising to ACK rising; legal range 1..2^CNT_W-1.
REQ-003 SHALL have parameter CNT_W, default 5: width of the idle and wake counters.
REQ-004 CK  input  1  free-running (ungated) clock; all state updates on its rising edge.
REQ-005 RN  input  1  reset, asynchronous, active-low.
REQ-006 REQ  input  1  client request for a running gated clock.
REQ-007 BUSY  input  1  gated-domain busy indication.
REQ-008 FORCE_ON  input  1  software override that keeps the clock running.
REQ-009 TE  input  1  scan/test enable.
REQ-010 E  output  1  functional enable to the ICG cell E pin; registered.
REQ-011 SE  output  1  test enable to the ICG cell SE pin.
REQ-012 ACK  output  1  gated clock running and stable; registered.
REQ-013 STATE  output  2  current state code: OFF=00, WAKE=01, ON=10, DRAIN=11.

Function
REQ-014 SHALL define act = REQ | BUSY | FORCE_ON, sampled at each CK rising edge.
REQ-015 SHALL drive SE = TE combinationally; TE SHALL NOT affect FSM state, counters, E or ACK.
REQ-016 SHALL drive E = 1 in WAKE, ON and DRAIN, and E = 0 in OFF.
REQ-017 SHALL drive ACK = 1 in ON and DRAIN, and ACK = 0 in OFF and WAKE.
REQ-018 OFF: act=1 -> WAKE with wake_cnt cleared; act=0 -> remain in OFF.
REQ-019 WAKE: wake_cnt increments each cycle; at the edge where wake_cnt = WAKE_CYC-1 -> ON with idle_cnt cleared; act is ignored in WAKE, so wake always completes.
REQ-020 ON: act=1 -> remain in ON with idle_cnt=0; act=0 -> idle_cnt=1, then DRAIN, or OFF directly if IDLE_CYC=1.
REQ-021 DRAIN: act=1 -> ON with idle_cnt=0.
REQ-022 DRAIN: act=0 with idle_cnt = IDLE_CYC-1 -> OFF with idle_cnt=0.
REQ-023 DRAIN: act=0 otherwise -> idle_cnt increments and the state remains DRAIN.
REQ-024 Latency: E SHALL rise on the first edge sampling act=1 in OFF.
REQ-025 Latency: ACK SHALL rise exactly WAKE_CYC edges after E rises.
REQ-026 Latency: E and ACK SHALL fall together on the IDLE_CYC-th consecutive edge sampling act=0 in ON or DRAIN.
REQ-027 Counters SHALL never wrap; parameter legality SHALL be enforced by elaboration-time check.
REQ-028 act pulsing 1 for a single cycle in DRAIN SHALL restart the full IDLE_CYC idle count.
REQ-029 act=1 on the same edge that OFF would be entered SHALL take priority: the state goes to ON, not OFF.
REQ-030 Decision logic SHALL be glitch-free; E SHALL come from a flop output only, with no combinational path from REQ, BUSY or FORCE_ON to E.

Reset
REQ-031 RN=0 SHALL asynchronously force STATE=OFF, E=0, ACK=0, idle_cnt=0 and wake_cnt=0.
REQ-032 SE SHALL continue to follow TE during reset.
REQ-033 On RN deassertion, the FSM SHALL begin evaluating act at the first subsequent CK rising edge.
REQ-034 Reset asserted mid-WAKE or mid-DRAIN SHALL abandon the operation with no residual count.

Verification
REQ-035 Wake: defaults, OFF, REQ=1 held from edge 0 -> E=1 after edge 0, ACK=1 after edge 2, STATE=ON.
REQ-036 Idle-off: ON, all act inputs drop before edge k -> STATE=DRAIN after edge k, E=ACK=0 and STATE=OFF after edge k+15, and not earlier.
REQ-037 Drain abort: DRAIN with idle_cnt=10, BUSY=1 for one cycle -> STATE=ON, idle_cnt=0; OFF then requires 16 more inactive edges.
REQ-038 Test mode: TE toggled 0/1 in OFF with act=0 -> SE tracks TE every cycle while E, ACK and STATE stay 0.
REQ-039 Async reset: RN pulsed low mid-WAKE between clock edges -> E=0, ACK=0, STATE=OFF immediately; a REQ after release takes the full WAKE_CYC again.
REQ-040 Parameter corners: IDLE_CYC=1 and WAKE_CYC=1 -> ON to OFF on the first inactive edge, and ACK one edge after E.
